// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Define MDU_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops (7-10).
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif
  localparam logic [4:0] MULT_LD = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_LD  = 5'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  logic        is_mult, is_div;
  logic [63:0] a_sx, b_sx, prod_s, prod_u, res;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        div_zero;

  always_comb begin
    is_mult = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
`ifdef MDU_MADD_EN
    is_mult = is_mult || ((mdu_op >= OP_MADD) && (mdu_op <= OP_MSUBU));
`endif
    is_div  = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
  end

  // Signed divide works on magnitudes so INT_MIN / -1 wraps to 0x80000000 cleanly.
  always_comb begin
    a_sx     = {{32{a_q[31]}}, a_q};
    b_sx     = {{32{b_q[31]}}, b_q};
    prod_s   = a_sx * b_sx;
    prod_u   = {32'd0, a_q} * {32'd0, b_q};
    a_mag    = a_q[31] ? (32'd0 - a_q) : a_q;
    b_mag    = b_q[31] ? (32'd0 - b_q) : b_q;
    div_zero = (b_q == 32'd0);
    q_mag    = div_zero ? 32'd0 : (a_mag / b_mag);
    r_mag    = div_zero ? 32'd0 : (a_mag % b_mag);
    q_u      = div_zero ? 32'd0 : (a_q / b_q);
    r_u      = div_zero ? 32'd0 : (a_q % b_q);
    q_s      = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
    r_s      = a_q[31] ? (32'd0 - r_mag) : r_mag;
    res      = {hi_q, lo_q};
    case (op_q)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   res = {r_s, q_s};
      OP_DIVU:  res = {r_u, q_u};
`ifdef MDU_MADD_EN
      OP_MADD:  res = {hi_q, lo_q} + prod_s;
      OP_MADDU: res = {hi_q, lo_q} + prod_u;
      OP_MSUB:  res = {hi_q, lo_q} - prod_s;
      OP_MSUBU: res = {hi_q, lo_q} - prod_u;
`endif
      default:  res = {hi_q, lo_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_mult || is_div) begin
            op_d    = mdu_op;
            a_d     = A;
            b_d     = B;
            cnt_d   = is_div ? DIV_LD : MULT_LD;
            state_d = RUN;
          end else if (mdu_op == OP_MTHI) begin
            hi_d = A;
          end else if (mdu_op == OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
          // A zero divisor still takes the full latency but leaves HI/LO alone.
          if (!(((op_q == OP_DIV) || (op_q == OP_DIVU)) && div_zero)) begin
            {hi_d, lo_d} = res;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases with literal results plus
// a randomized run checked every cycle against an arithmetic reference model.
module tb_mult_div_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  mduOp = 4'd0;
   logic [31:0] opA = 32'd0;
   logic [31:0] opB = 32'd0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int vectors = 0;
   int miscompares = 0;

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .mdu_op(mduOp),
      .A(opA), .B(opB), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   // Single comparison point: every check in the bench funnels through here
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference result of a launched op, computed with plain 64-bit arithmetic
   function automatic void refOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] h, input logic [31:0] l,
                                 output bit launch, output bit wr, output int lat,
                                 output logic [63:0] r);
      longint sa, sb, q, rm;
      longint unsigned ua, ub, hl;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      hl = {h, l};
      launch = 1'b0;
      wr = 1'b1;
      lat = MC;
      r = hl;
      case (op)
         4'd1: begin launch = 1'b1; r = 64'(sa * sb); end
         4'd2: begin launch = 1'b1; r = ua * ub; end
         4'd3: begin
            launch = 1'b1; lat = DC;
            if (b == 32'd0) wr = 1'b0;
            else begin q = sa / sb; rm = sa % sb; r = {rm[31:0], q[31:0]}; end
         end
         4'd4: begin
            launch = 1'b1; lat = DC;
            if (b == 32'd0) wr = 1'b0;
            else r = {32'(ua % ub), 32'(ua / ub)};
         end
`ifdef MDU_MADD_EN
         4'd7:  begin launch = 1'b1; r = hl + 64'(sa * sb); end
         4'd8:  begin launch = 1'b1; r = hl + ua * ub; end
         4'd9:  begin launch = 1'b1; r = hl - 64'(sa * sb); end
         4'd10: begin launch = 1'b1; r = hl - ua * ub; end
`endif
         default: ;
      endcase
   endfunction

   logic        mBusy, mDone, mWrite;
   logic [31:0] mHi, mLo;
   logic [63:0] mPend;
   int          cyc = 0;
   int          commitAt;

   // Cycle stamp used by the model to know when a launched op must commit
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural model: an accepted op commits exactly 'latency' edges later
   always @(posedge clk or negedge reset) begin : model
      bit          launch, wr;
      int          lat;
      logic [63:0] r;
      if (!reset) begin
         mBusy <= 1'b0; mDone <= 1'b0; mWrite <= 1'b0;
         mHi <= 32'd0; mLo <= 32'd0; mPend <= 64'd0; commitAt <= 0;
      end else begin
         mDone <= 1'b0;
         if (mBusy) begin
            if (cyc == commitAt) begin
               mBusy <= 1'b0;
               mDone <= 1'b1;
               if (mWrite) begin mHi <= mPend[63:32]; mLo <= mPend[31:0]; end
            end
         end else if (start) begin
            if (mduOp == 4'd5) mHi <= opA;
            else if (mduOp == 4'd6) mLo <= opA;
            else begin
               refOp(mduOp, opA, opB, mHi, mLo, launch, wr, lat, r);
               if (launch) begin
                  mBusy <= 1'b1; mWrite <= wr; mPend <= r; commitAt <= cyc + lat;
               end
            end
         end
      end
   end

   // Compare every output against the model on each falling edge
   always @(negedge clk) begin
      checkOutput("model_busy", {63'd0, busy}, {63'd0, mBusy});
      checkOutput("model_done", {63'd0, done}, {63'd0, mDone});
      checkOutput("model_hi", {32'd0, hi}, {32'd0, mHi});
      checkOutput("model_lo", {32'd0, lo}, {32'd0, mLo});
   end

   // Drive one start pulse sampled by a single rising edge
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; mduOp = op; opA = a; opB = b;
      @(negedge clk);
      start = 1'b0; mduOp = 4'd0; opA = $urandom; opB = $urandom;
   endtask

   // Count busy falling edges until idle, bounded so a stuck DUT cannot hang the run
   task automatic waitIdle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 64) begin
         n++;
         @(negedge clk);
      end
      if (n >= 64) checkOutput("busy_timeout", 64'd1, 64'd0);
   endtask

   // Launch one op and check latency, done pulse and committed HI/LO literals
   task automatic runOp(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int expCycles,
                        input logic [31:0] expHi, input logic [31:0] expLo);
      int n;
      applyStimulus(op, a, b);
      waitIdle(n);
      checkOutput({name, "_cycles"}, 64'(n), 64'(expCycles));
      checkOutput({name, "_done"}, {63'd0, done}, 64'd1);
      checkOutput({name, "_hi"}, {32'd0, hi}, {32'd0, expHi});
      checkOutput({name, "_lo"}, {32'd0, lo}, {32'd0, expLo});
      @(negedge clk);
      checkOutput({name, "_done_drop"}, {63'd0, done}, 64'd0);
   endtask

   function automatic logic [31:0] rnd32();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Directed scenarios followed by a randomized soak
   initial begin
      int n;
      #1 reset = 1'b0;
      #1;
      checkOutput("reset_busy", {63'd0, busy}, 64'd0);
      checkOutput("reset_done", {63'd0, done}, 64'd0);
      checkOutput("reset_hi", {32'd0, hi}, 64'd0);
      checkOutput("reset_lo", {32'd0, lo}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      applyStimulus(4'd5, 32'h1234, 32'd0);
      checkOutput("mthi_hi", {32'd0, hi}, 64'h1234);
      applyStimulus(4'd1, 32'd7, 32'd9);
      @(negedge clk);
      #1 reset = 1'b0;
      #1;
      checkOutput("abort_busy", {63'd0, busy}, 64'd0);
      checkOutput("abort_hi", {32'd0, hi}, 64'd0);
      checkOutput("abort_lo", {32'd0, lo}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (12) begin
         @(negedge clk);
         checkOutput("abort_no_done", {63'd0, done}, 64'd0);
      end

      runOp("mult", 4'd1, 32'hFFFF_FFFD, 32'd5, MC, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      runOp("multu", 4'd2, 32'hFFFF_FFFD, 32'd5, MC, 32'h0000_0004, 32'hFFFF_FFF1);
      runOp("div", 4'd3, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      runOp("divu", 4'd4, 32'd7, 32'd2, DC, 32'd1, 32'd3);
      runOp("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'd0, 32'h8000_0000);
      applyStimulus(4'd5, 32'hAA, 32'd0);
      applyStimulus(4'd6, 32'hBB, 32'd0);
      runOp("divu_zero", 4'd4, 32'd7, 32'd0, DC, 32'hAA, 32'hBB);

      // Collisions: mtlo and a second mult while busy must both be dropped
      applyStimulus(4'd1, 32'd3, 32'd4);
      start = 1'b1; mduOp = 4'd6; opA = 32'h55; opB = 32'd0;
      @(negedge clk);
      start = 1'b1; mduOp = 4'd1; opA = 32'd100; opB = 32'd100;
      @(negedge clk);
      start = 1'b0; mduOp = 4'd0;
      waitIdle(n);
      checkOutput("collide_cycles", 64'(n), 64'(MC - 2));
      checkOutput("collide_done", {63'd0, done}, 64'd1);
      checkOutput("collide_lo", {32'd0, lo}, 64'd12);
      checkOutput("collide_hi", {32'd0, hi}, 64'd0);
      start = 1'b1; mduOp = 4'd1; opA = 32'd6; opB = 32'd7;
      @(negedge clk);
      start = 1'b0; mduOp = 4'd0;
      checkOutput("b2b_busy", {63'd0, busy}, 64'd1);
      waitIdle(n);
      checkOutput("b2b_cycles", 64'(n), 64'(MC));
      checkOutput("b2b_lo", {32'd0, lo}, 64'd42);

      repeat (1500) begin
         @(negedge clk);
         start = ($urandom_range(0, 2) == 0);
         mduOp = 4'($urandom_range(0, 15));
         opA = rnd32();
         opB = rnd32();
      end
      @(negedge clk);
      start = 1'b0; mduOp = 4'd0;
      waitIdle(n);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
